// File: rtl/seq194_ctrl.sv
// Command sequencer for a _74HC194 universal shift register: load / shift / rotate over START-BUSY-DONE.
// Optional feature macro: SEQ194_ROTATE_EN (rotate right for OP=11; otherwise OP=11 is rejected with ERR).
module seq194_ctrl #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             START,
   input  logic [1:0]       OP,
   input  logic [3:0]       DIN,
   input  logic [CNT_W-1:0] CNT,
   input  logic             SIN,
   input  logic [3:0]       Q,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [1:0]       S,
   output logic [3:0]       D,
   output logic             SER
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] rem, rem_nxt;
   logic [1:0]       op_q, op_nxt;
   logic [3:0]       d_nxt;
   logic [1:0]       s_nxt;
   logic             busy_nxt, done_nxt, err_nxt;
   logic             reject;

`ifdef SEQ194_ROTATE_EN
   assign reject = 1'b0;
`else
   assign reject = (OP == 2'b11);
`endif

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state <= IDLE;
         rem   <= '0;
         op_q  <= 2'b00;
         D     <= '0;
         S     <= 2'b00;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         ERR   <= 1'b0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
         op_q  <= op_nxt;
         D     <= d_nxt;
         S     <= s_nxt;
         BUSY  <= busy_nxt;
         DONE  <= done_nxt;
         ERR   <= err_nxt;
      end
   end

   // FIN accepts START exactly like IDLE so commands can run back to back
   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      op_nxt    = op_q;
      d_nxt     = D;
      err_nxt   = 1'b0;
      unique case (state)
         IDLE, FIN: begin
            state_nxt = IDLE;
            if (START) begin
               if (reject) begin
                  err_nxt = 1'b1;
               end else begin
                  op_nxt = OP;
                  d_nxt  = DIN;
                  if (OP == 2'b00) begin
                     rem_nxt   = CNT_W'(1);
                     state_nxt = RUN;
                  end else if (CNT != '0) begin
                     rem_nxt   = CNT;
                     state_nxt = RUN;
                  end else begin
                     rem_nxt   = '0;
                     state_nxt = FIN;
                  end
               end
            end
         end
         RUN: begin
            rem_nxt = rem - CNT_W'(1);
            if (rem == CNT_W'(1)) state_nxt = FIN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs are decoded from the next state so they line up with it
   always_comb begin
      s_nxt    = 2'b00;
      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == FIN);
      if (state_nxt == RUN) begin
         unique case (op_nxt)
            2'b00:   s_nxt = 2'b11;
            2'b01:   s_nxt = 2'b01;
            2'b10:   s_nxt = 2'b10;
            default: s_nxt = 2'b01;
         endcase
      end
   end

   always_comb begin
      SER = 1'b0;
      if (state == RUN) begin
         if (op_q == 2'b01 || op_q == 2'b10) SER = SIN;
`ifdef SEQ194_ROTATE_EN
         else if (op_q == 2'b11) SER = Q[3];
`endif
      end
   end

`ifndef SEQ194_ROTATE_EN
   logic unused_q;
   assign unused_q = ^Q;
`endif

endmodule

// File: tb/tb_seq194_ctrl.sv
// Self-checking bench for seq194_ctrl with a behavioural _74HC194 attached to its pins.
module tb_seq194_ctrl;
   localparam int unsigned CNT_W = 4;
`ifdef SEQ194_ROTATE_EN
   localparam logic [3:0] ROT_EXP = 4'b0100;
`else
   localparam logic [3:0] ROT_EXP = 4'b1000;
`endif

   logic             CLK = 1'b0;
   logic             CLR, START, SIN;
   logic [1:0]       OP;
   logic [3:0]       DIN;
   logic [CNT_W-1:0] CNT;
   logic [3:0]       Q;
   logic             BUSY, DONE, ERR, SER;
   logic [1:0]       S;
   logic [3:0]       D;

   logic [3:0] q = '0;
   logic [3:0] last_d = '0;
   int n_cmp = 0;
   int n_fail = 0;

   assign Q = q;
   always #5 CLK = ~CLK;

   seq194_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .CLR(CLR), .START(START), .OP(OP), .DIN(DIN), .CNT(CNT), .SIN(SIN),
      .Q(Q), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .S(S), .D(D), .SER(SER)
   );

   // the shift register device itself
   always @(posedge CLK) begin
      case (S)
         2'b01:   q <= {q[2:0], SER};
         2'b10:   q <= {SER, q[3:1]};
         2'b11:   q <= D;
         default: q <= q;
      endcase
   end

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  din;
      int unsigned cnt;
      bit          sin;
      logic [3:0]  init;
      logic [3:0]  exp_q;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] mode_of(input logic [1:0] op);
      return (op == 2'b00) ? 2'b11 : (op == 2'b10) ? 2'b10 : 2'b01;
   endfunction

   // one register step as arithmetic on the 4-bit value
   function automatic logic [3:0] step(input logic [1:0] op, input logic [3:0] v,
                                       input bit sb, input logic [3:0] din);
      int unsigned x;
      x = 32'(v);
      case (op)
         2'b00:   return din;
         2'b01:   return 4'((x * 2 + 32'(sb)) % 16);
         2'b10:   return 4'(x / 2 + 32'(sb) * 8);
         default: return 4'((x * 2 + x / 8) % 16);
      endcase
   endfunction

   task automatic run_cmd(input logic [1:0] op, input logic [3:0] din, input int unsigned cnt,
                          input bit rnd, input bit sin_c, output logic [3:0] qfin);
      bit rej, eb, ed, ee, sb, eser;
      int unsigned n, last;
      logic [3:0] mq, ed_d;
      logic [1:0] es;
      rej = 1'b0;
`ifndef SEQ194_ROTATE_EN
      rej = (op == 2'b11);
`endif
      n    = (op == 2'b00) ? 1 : cnt;
      last = (rej || n == 0) ? 1 : n + 1;
      mq   = q;
      qfin = q;
      ed_d = rej ? last_d : din;
      @(negedge CLK);
      START = 1'b1; OP = op; DIN = din; CNT = CNT_W'(cnt); SIN = 1'($urandom);
      for (int unsigned j = 1; j <= last; j++) begin
         @(negedge CLK);
         eb = !rej && j <= n;
         ed = !rej && j == ((n == 0) ? 1 : n + 1);
         ee = rej && j == 1;
         es = eb ? mode_of(op) : 2'b00;
         chk("busy", 32'(BUSY), 32'(eb));
         chk("done", 32'(DONE), 32'(ed));
         chk("err", 32'(ERR), 32'(ee));
         chk("s", 32'(S), 32'(es));
         if (j == last) begin
            chk("q_final", 32'(Q), 32'(mq));
            chk("d_latched", 32'(D), 32'(ed_d));
            qfin = Q;
         end
         START = eb ? 1'($urandom) : 1'b0;
         if (eb) begin
            OP = 2'($urandom); DIN = 4'($urandom); CNT = CNT_W'($urandom);
         end
         sb  = rnd ? 1'($urandom) : sin_c;
         SIN = sb;
         #1;
         eser = 1'b0;
         if (eb && op != 2'b00) eser = (op == 2'b11) ? mq[3] : sb;
         chk("ser", 32'(SER), 32'(eser));
         if (eb) mq = step(op, mq, sb, din);
      end
      START = 1'b0;
      last_d = ed_d;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not end, expected finish before 1ms");
      $fatal(1);
   end

   initial begin
      logic [3:0] qf;
      CLR = 1'b0; START = 1'b0; OP = '0; DIN = '0; CNT = '0; SIN = 1'b0;

      tbl[0] = '{op: 2'b00, din: 4'b1100, cnt: 0,  sin: 1'b0, init: 4'b0000, exp_q: 4'b1100};
      tbl[1] = '{op: 2'b01, din: 4'b0110, cnt: 2,  sin: 1'b1, init: 4'b1100, exp_q: 4'b0011};
      tbl[2] = '{op: 2'b10, din: 4'b1001, cnt: 1,  sin: 1'b0, init: 4'b1100, exp_q: 4'b0110};
      tbl[3] = '{op: 2'b11, din: 4'b0101, cnt: 3,  sin: 1'b0, init: 4'b1000, exp_q: ROT_EXP};
      tbl[4] = '{op: 2'b01, din: 4'b0011, cnt: 0,  sin: 1'b1, init: 4'b1010, exp_q: 4'b1010};
      tbl[5] = '{op: 2'b10, din: 4'b1110, cnt: 15, sin: 1'b1, init: 4'b0000, exp_q: 4'b1111};
      tbl[6] = '{op: 2'b11, din: 4'b0001, cnt: 4,  sin: 1'b1, init: 4'b1011, exp_q: 4'b1011};

      #12;
      chk("rst_s", 32'(S), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_d", 32'(D), 32'd0);
      @(negedge CLK);
      CLR = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_cmd(2'b00, tbl[i].init, 0, 1'b0, 1'b0, qf);
         run_cmd(tbl[i].op, tbl[i].din, tbl[i].cnt, 1'b0, tbl[i].sin, qf);
         chk("tbl_q", 32'(qf), 32'(tbl[i].exp_q));
      end

      // START in the FIN cycle of a load launches a shift left with no idle gap
      run_cmd(2'b00, 4'b0000, 0, 1'b0, 1'b0, qf);
      @(negedge CLK);
      START = 1'b1; OP = 2'b00; DIN = 4'b1100; CNT = '0;
      @(negedge CLK);
      START = 1'b0;
      chk("b2b_busy1", 32'(BUSY), 32'd1);
      @(negedge CLK);
      chk("b2b_done1", 32'(DONE), 32'd1);
      chk("b2b_q1", 32'(Q), 32'hC);
      START = 1'b1; OP = 2'b10; DIN = 4'b0111; CNT = CNT_W'(1); SIN = 1'b0;
      @(negedge CLK);
      START = 1'b0;
      chk("b2b_busy2", 32'(BUSY), 32'd1);
      chk("b2b_s2", 32'(S), 32'd2);
      chk("b2b_done_gap", 32'(DONE), 32'd0);
      @(negedge CLK);
      chk("b2b_done2", 32'(DONE), 32'd1);
      chk("b2b_q2", 32'(Q), 32'h6);
      chk("b2b_d2", 32'(D), 32'h7);
      last_d = 4'b0111;

      // asynchronous reset while a shift has rem=3 left
      run_cmd(2'b00, 4'b1100, 0, 1'b0, 1'b0, qf);
      @(negedge CLK);
      START = 1'b1; OP = 2'b01; DIN = 4'b0101; CNT = CNT_W'(5); SIN = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("mid_busy", 32'(BUSY), 32'd1);
      chk("mid_q", 32'(Q), 32'h3);
      #2 CLR = 1'b0;
      #1;
      chk("arst_s", 32'(S), 32'd0);
      chk("arst_busy", 32'(BUSY), 32'd0);
      chk("arst_done", 32'(DONE), 32'd0);
      chk("arst_d", 32'(D), 32'd0);
      @(negedge CLK);
      CLR = 1'b1;
      last_d = '0;
      repeat (3) @(negedge CLK);
      chk("arst_q_frozen", 32'(Q), 32'h3);
      chk("arst_idle", 32'(BUSY), 32'd0);

      for (int i = 0; i < 60; i++) begin
         run_cmd(2'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4),
                 1'b1, 1'b0, qf);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seq194_ctrl.md
# seq194_ctrl

Command sequencer for the `_74HC194` 4-bit universal shift register. It accepts one-shot commands over a START/BUSY/DONE handshake: parallel load, shift right N steps, shift left N steps, or rotate right N steps. For each command it drives the register's `S`, `D` and `SER` pins for exactly the required number of clock edges. It sits between control logic and one `_74HC194` instance, shares that instance's `CLK`, and reads the register's `Q` back for rotation.

## Interface
- `CNT_W`, default 4: width of the step-count input; maximum steps = 2^CNT_W − 1.
- Clock and reset:
  - `CLK` in 1: clock, rising edge; the same clock drives the `_74HC194`.
  - `CLR` in 1: reset, asynchronous, active-low.
- Command side:
  - `START` in 1: command strobe; accepted only when `BUSY`=0.
  - `OP` in 2: 00 load, 01 shift right, 10 shift left, 11 rotate right.
  - `DIN` in 4: parallel load data.
  - `CNT` in CNT_W: step count for shift/rotate; ignored for load.
  - `SIN` in 1: serial data for shift ops; one bit consumed per active edge.
  - `BUSY` out 1: command in progress.
  - `DONE` out 1: one-cycle completion pulse.
  - `ERR` out 1: one-cycle pulse on a rejected command.
- Register side:
  - `Q` in 4: feedback from `_74HC194.Q`.
  - `S` out 2: mode select to `_74HC194` (00 hold, 01 right, 10 left, 11 load).
  - `D` out 4: parallel data to `_74HC194`.
  - `SER` out 1: serial input to `_74HC194`.

## Operation
- Register convention, applied at each edge: `S`=01 gives Q[0]←SER, Q[k]←Q[k−1]. `S`=10 gives Q[3]←SER, Q[k]←Q[k+1]. `S`=11 gives Q←D. `S`=00 holds.
- FSM states: IDLE, RUN, FIN.
  - IDLE: `START`=1 latches `OP`, `DIN`→`D` and `CNT`→`rem`; sets `BUSY`=1.
  - Load: go to RUN with `rem`=1.
  - Shift or rotate with `CNT`≥1: go to RUN.
  - Shift or rotate with `CNT`=0: go straight to FIN; `S` stays 00.
  - RUN: `S` = mode for `OP`. Each edge decrements `rem`. The edge where `rem`=1 moves to FIN, sets `S`=00, `BUSY`=0 and `DONE`=1.
  - FIN: lasts one cycle with `DONE`=1, then goes to IDLE. A `START` in FIN is accepted exactly as in IDLE, so back-to-back commands are allowed.
- `SER` is combinational:
  - `SIN` during RUN for OP 01/10.
  - `Q[3]` during RUN for OP 11.
  - 0 otherwise.
- `D` holds the latched `DIN` until the next accepted command.
- `START` while `BUSY`=1 is ignored; the latched command is unaffected and no `ERR` is raised.
- `DIN`, `CNT` and `OP` changes during RUN have no effect.
- Reset values, applied asynchronously on `CLR`=0:
  - state IDLE, `rem`=0.
  - `S`=00, `D`=0000, `BUSY`=0, `DONE`=0, `ERR`=0.
  - Reset mid-command aborts immediately; the register then holds, because `S`=00.

## Timing
- `S`, `D`, `BUSY`, `DONE` and `ERR` are registered. `SER` follows `SIN`/`Q` in the same cycle.
- `START` is sampled at edge e0. `S` is active from e0 to eN, so the `_74HC194` acts on edges e1..eN.
  - N = 1 for load, N = `CNT` for shift/rotate.
- At eN: `DONE` rises for one cycle and `BUSY` falls.
- Command latency is N+1 edges from `START` sample to `DONE` low.
- `CNT`=0: `DONE` rises at e0 and the register is untouched.
- `ERR` rises at e0 for one cycle. No state change occurs and `BUSY` stays 0.

## Configuration
- `SEQ194_ROTATE_EN`
  - Defined: OP=11 runs rotate right as above.
  - Undefined: OP=11 is rejected with an `ERR` pulse, and the `SER`←`Q[3]` path and its logic are removed.

## Test plan
- `CLR`=0 mid-shift with `rem`=3 → `S`=00, `BUSY`=0, `DONE`=0 immediately; after release, `Q` is frozen.
- Load `DIN`=1100 → `S`=11 for one cycle; `Q`=1100; `DONE` one cycle later; `BUSY` high exactly 1 cycle.
- Shift right, `CNT`=2, `SIN`=1, from 1100 → `Q`=1001 then 0011; `DONE` after 2nd edge. Shift left, `CNT`=1, `SIN`=0, from 1100 → `Q`=0110.
- Rotate right, `CNT`=3, from 1000 (`SEQ194_ROTATE_EN` defined) → 0001, 0010, 0100. Same stimulus with the macro undefined → `ERR` pulse, `Q` stays 1000.
- Shift, `CNT`=0 → `DONE` at e0, `S` never leaves 00. `START` pulsed while `BUSY` → ignored. `START` in the FIN cycle → next command accepted with no idle gap.
